irq_timer: RTL and testbench
============================

IRQ_TIMER -- requirements
Module: irq_timer

Interface
REQ-001 SHALL provide parameter RESET_RELOAD, default 16'hFFFF, the reload register value after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the falling edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port i_data  input  8  CPU write data.
REQ-005 SHALL have port o_data  output  8  CPU read data, combinational from addr.
REQ-006 SHALL have port addr  input  3  register select.
REQ-007 SHALL have port cs  input  1  chip select.
REQ-008 SHALL have port rwb  input  1  1 = read, 0 = write; we = cs & ~rwb, re = cs & rwb.
REQ-009 SHALL have port irq  output  1  level interrupt request, wired to one interrupt controller int_in bit.

Function
REQ-010 SHALL implement this register map: 0 RELOAD_LO (rw); 1 RELOAD_HI (rw); 2 CTRL (rw; bit0 EN, bit1 PERIODIC, bit2 IE, others read 0); 3 STATUS (bit0 FLAG, write-1-to-clear); 4 PRESCALE (rw); 5 COUNT_LO (ro); 6 COUNT_HI snapshot (ro); 7 reads 8'h00.
REQ-011 SHALL ignore writes to addresses 5, 6 and 7.
REQ-012 SHALL keep a 16-bit down counter COUNT and an 8-bit prescale counter PCNT.
REQ-013 SHALL, on a CTRL write that sets EN while EN is 0, load COUNT from RELOAD and clear PCNT on the same edge, with no tick on that edge.
REQ-014 SHALL, while EN = 1, generate a tick on an edge where PCNT == PRESCALE and clear PCNT; otherwise it SHALL increment PCNT.
REQ-015 SHALL, on a tick with COUNT != 0, decrement COUNT by 1.
REQ-016 SHALL, on a tick with COUNT == 0, set FLAG; if PERIODIC = 1 it SHALL reload COUNT from RELOAD, otherwise it SHALL clear EN and hold COUNT at 0.
REQ-017 SHALL give a period of (RELOAD+1)*(PRESCALE+1) clocks from enable to the first FLAG set, and the same interval between later sets.
REQ-018 SHALL apply RELOAD writes made while running only at the next reload or enable, never to COUNT directly.
REQ-019 SHALL freeze COUNT and PCNT when EN is cleared, whether by a CPU write or by one-shot expiry.
REQ-020 SHALL let a set win over a clear when a FLAG set and a STATUS write-1-to-clear occur on the same edge.
REQ-021 SHALL drive irq = FLAG & IE, computed from register bits only and therefore glitch-free.
REQ-022 SHALL, on an edge with re and addr == 5, copy COUNT[15:8] into the COUNT_HI snapshot.
REQ-023 SHALL return COUNT[7:0] combinationally on a read of addr 5, so a LO-then-HI read pair is tear-free.
REQ-024 SHALL leave the snapshot unchanged on a read of addr 6.
REQ-025 SHALL leave the FLAG state unchanged when IE is cleared, so FLAG keeps its value and irq drops.

Reset
REQ-026 SHALL, while reset is asserted, asynchronously force: COUNT = 0, PCNT = 0, CTRL = 0, FLAG = 0, PRESCALE = 0, snapshot = 0, RELOAD = RESET_RELOAD, irq = 0.
REQ-027 SHALL abandon any in-progress countdown on reset mid-operation, with no FLAG set after reset release until EN is written again.

Configuration
REQ-028 SHALL include the prescaler only when IRQ_TIMER_PRESCALE_EN is defined, behaving per REQ-014.
REQ-029 SHALL, without IRQ_TIMER_PRESCALE_EN, tick on every enabled edge, read PRESCALE as 8'h00, ignore writes to it, and synthesize no PCNT flops.

Verification
REQ-030 SHALL cover one-shot: RELOAD = 3, PRESCALE = 0, CTRL = 8'h05 -> FLAG and irq rise 4 clocks after the write edge, EN reads 0, COUNT stays 0.
REQ-031 SHALL cover periodic with prescale: RELOAD = 1, PRESCALE = 2, CTRL = 8'h07, FLAG cleared after each set -> FLAG sets every 6 clocks across 3 periods.
REQ-032 SHALL cover a simultaneous clear: STATUS write 8'h01 on the same edge as expiry -> FLAG remains 1, irq remains 1.
REQ-033 SHALL cover a tear-free read: RELOAD = 16'h0100, read COUNT_LO when COUNT = 16'h0100, then read COUNT_HI 5 clocks later -> reads 8'h00 then 8'h01.
REQ-034 SHALL cover reset mid-run: assert reset with COUNT = 16'h0010 in periodic mode -> COUNT, CTRL, FLAG and irq read 0 and RELOAD reads 16'hFFFF immediately, with no irq for 100 clocks after release.
REQ-035 SHALL cover the macro off: build without IRQ_TIMER_PRESCALE_EN, write PRESCALE = 8'h05, RELOAD = 2, one-shot -> PRESCALE reads 8'h00 and FLAG sets after 3 clocks.

Source files
------------

// File: rtl/irq_timer.sv
// Memory-mapped 16-bit down-counting interrupt timer with a one-shot or periodic mode.
// Optional prescaler is built only when IRQ_TIMER_PRESCALE_EN is defined.
module irq_timer #(
    parameter logic [15:0] RESET_RELOAD = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    input  logic [2:0] addr,
    input  logic       cs,
    input  logic       rwb,
    output logic       irq
);
    localparam int unsigned DW = 8;
    localparam int unsigned CW = 16;

    localparam logic [2:0] A_RLO  = 3'd0;
    localparam logic [2:0] A_RHI  = 3'd1;
    localparam logic [2:0] A_CTRL = 3'd2;
    localparam logic [2:0] A_STAT = 3'd3;
    localparam logic [2:0] A_PRE  = 3'd4;
    localparam logic [2:0] A_CLO  = 3'd5;
    localparam logic [2:0] A_CHI  = 3'd6;

    logic [CW-1:0] r_reload;
    logic [CW-1:0] r_count;
    logic [2:0]    r_ctrl;      // {IE, PERIODIC, EN}
    logic          r_flag;
    logic [DW-1:0] r_snap_hi;
`ifdef IRQ_TIMER_PRESCALE_EN
    logic [DW-1:0] r_prescale;
    logic [DW-1:0] r_pcnt;
`endif

    logic w_we;
    logic w_re;
    logic w_start;
    logic w_tick;
    logic w_expire;
    logic w_flag_clr;

    always_comb begin
        w_we       = cs & ~rwb;
        w_re       = cs & rwb;
        w_start    = w_we && (addr == A_CTRL) && i_data[0] && !r_ctrl[0];
`ifdef IRQ_TIMER_PRESCALE_EN
        w_tick     = r_ctrl[0] && (r_pcnt == r_prescale);
`else
        w_tick     = r_ctrl[0];
`endif
        w_expire   = w_tick && (r_count == CW'(0));
        w_flag_clr = w_we && (addr == A_STAT) && i_data[0];
    end

    // All state advances on the falling edge of clk
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_reload   <= RESET_RELOAD;
            r_count    <= '0;
            r_ctrl     <= '0;
            r_flag     <= 1'b0;
            r_snap_hi  <= '0;
`ifdef IRQ_TIMER_PRESCALE_EN
            r_prescale <= '0;
            r_pcnt     <= '0;
`endif
        end else begin
            if (w_we) begin
                case (addr)
                    A_RLO:   r_reload[7:0]  <= i_data;
                    A_RHI:   r_reload[15:8] <= i_data;
                    A_CTRL:  r_ctrl         <= i_data[2:0];
`ifdef IRQ_TIMER_PRESCALE_EN
                    A_PRE:   r_prescale     <= i_data;
`endif
                    default: ;
                endcase
            end

            if (w_start) begin
                r_count <= r_reload;
`ifdef IRQ_TIMER_PRESCALE_EN
                r_pcnt  <= '0;
`endif
            end else if (r_ctrl[0]) begin
`ifdef IRQ_TIMER_PRESCALE_EN
                r_pcnt <= w_tick ? DW'(0) : r_pcnt + DW'(1);
`endif
                if (w_tick) begin
                    if (r_count != CW'(0)) begin
                        r_count <= r_count - CW'(1);
                    end else if (r_ctrl[1]) begin
                        r_count <= r_reload;
                    end else begin
                        // One-shot expiry disarms even if the CPU writes CTRL on this edge
                        r_ctrl[0] <= 1'b0;
                    end
                end
            end

            // A set on the expiry edge beats a simultaneous write-1-to-clear
            if (w_expire) begin
                r_flag <= 1'b1;
            end else if (w_flag_clr) begin
                r_flag <= 1'b0;
            end

            if (w_re && (addr == A_CLO)) begin
                r_snap_hi <= r_count[15:8];
            end
        end
    end

    always_comb begin
        o_data = '0;
        case (addr)
            A_RLO:   o_data = r_reload[7:0];
            A_RHI:   o_data = r_reload[15:8];
            A_CTRL:  o_data = {5'b0, r_ctrl};
            A_STAT:  o_data = {7'b0, r_flag};
`ifdef IRQ_TIMER_PRESCALE_EN
            A_PRE:   o_data = r_prescale;
`endif
            A_CLO:   o_data = r_count[7:0];
            A_CHI:   o_data = r_snap_hi;
            default: o_data = '0;
        endcase
    end

    assign irq = r_flag & r_ctrl[2];

endmodule

// File: tb/tb_irq_timer.sv
// Directed self-checking bench for irq_timer; expected timings adapt to IRQ_TIMER_PRESCALE_EN.
module tb_irq_timer;
`ifdef IRQ_TIMER_PRESCALE_EN
    localparam int PS_ON = 1;
`else
    localparam int PS_ON = 0;
`endif

    logic       clk;
    logic       reset;
    logic [7:0] i_data;
    logic [7:0] o_data;
    logic [2:0] addr;
    logic       cs;
    logic       rwb;
    logic       irq;

    int checks = 0;
    int errors = 0;
    logic [7:0] rdat;
    int per;

    irq_timer dut (
        .clk    (clk),
        .reset  (reset),
        .i_data (i_data),
        .o_data (o_data),
        .addr   (addr),
        .cs     (cs),
        .rwb    (rwb),
        .irq    (irq)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bus cycle: drive after a rising edge, the DUT acts on the following falling edge
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(posedge clk);
        cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
        @(negedge clk);
        #1;
        cs = 1'b0; rwb = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(posedge clk);
        cs = 1'b1; rwb = 1'b1; addr = a;
        #1;
        d = o_data;
        @(negedge clk);
        #1;
        cs = 1'b0;
    endtask

    task automatic peek(input logic [2:0] a, output logic [7:0] d);
        addr = a;
        #1;
        d = o_data;
    endtask

    initial begin
        reset = 1'b1; cs = 1'b0; rwb = 1'b1; addr = '0; i_data = '0;

        // Reset state
        #1;
        chk("rst_irq", 16'(irq), 16'h0);
        peek(3'd0, rdat); chk("rst_rlo", 16'(rdat), 16'h00FF);
        peek(3'd1, rdat); chk("rst_rhi", 16'(rdat), 16'h00FF);
        peek(3'd2, rdat); chk("rst_ctrl", 16'(rdat), 16'h0000);
        peek(3'd3, rdat); chk("rst_stat", 16'(rdat), 16'h0000);
        peek(3'd5, rdat); chk("rst_clo", 16'(rdat), 16'h0000);
        peek(3'd6, rdat); chk("rst_chi", 16'(rdat), 16'h0000);
        @(posedge clk);
        reset = 1'b0;

        // One-shot: RELOAD=3, PRESCALE=0 -> FLAG 4 clocks after enable
        wr(3'd0, 8'h03); wr(3'd1, 8'h00); wr(3'd4, 8'h00); wr(3'd2, 8'h05);
        repeat (3) @(negedge clk);
        #1; chk("os_pre", 16'(irq), 16'h0);
        @(negedge clk);
        #1; chk("os_set", 16'(irq), 16'h1);
        rd(3'd2, rdat); chk("os_ctrl", 16'(rdat), 16'h0004);
        rd(3'd5, rdat); chk("os_cnt", 16'(rdat), 16'h0000);
        repeat (3) @(negedge clk);
        rd(3'd5, rdat); chk("os_cnt_hold", 16'(rdat), 16'h0000);

        // Clearing IE drops irq but keeps FLAG
        wr(3'd2, 8'h00);
        chk("ie_irq", 16'(irq), 16'h0);
        rd(3'd3, rdat); chk("ie_flag", 16'(rdat), 16'h0001);
        wr(3'd3, 8'h01);
        rd(3'd3, rdat); chk("w1c_flag", 16'(rdat), 16'h0000);

        // Periodic: RELOAD=1, PRESCALE=2
        per = 2 * (PS_ON != 0 ? 3 : 1);
        wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd4, 8'h02); wr(3'd2, 8'h07);
        repeat (per - 1) @(negedge clk);
        #1; chk("per0_pre", 16'(irq), 16'h0);
        @(negedge clk);
        #1; chk("per0_set", 16'(irq), 16'h1);
        for (int k = 1; k < 3; k++) begin
            wr(3'd3, 8'h01);
            repeat (per - 2) @(negedge clk);
            #1; chk("perN_pre", 16'(irq), 16'h0);
            @(negedge clk);
            #1; chk("perN_set", 16'(irq), 16'h1);
        end
        wr(3'd2, 8'h00);
        wr(3'd3, 8'h01);
        chk("per_stop", 16'(irq), 16'h0);

        // Write-1-to-clear on the expiry edge loses to the set
        wr(3'd0, 8'h03); wr(3'd1, 8'h00); wr(3'd4, 8'h00); wr(3'd2, 8'h05);
        repeat (3) @(negedge clk);
        wr(3'd3, 8'h01);
        chk("sim_irq", 16'(irq), 16'h1);
        rd(3'd3, rdat); chk("sim_flag", 16'(rdat), 16'h0001);
        wr(3'd3, 8'h01);
        chk("sim_clr", 16'(irq), 16'h0);

        // Tear-free COUNT read and freeze on disable
        wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h01);
        rd(3'd5, rdat); chk("tf_lo", 16'(rdat), 16'h0000);
        repeat (4) @(negedge clk);
        rd(3'd6, rdat); chk("tf_hi", 16'(rdat), 16'h0001);
        rd(3'd6, rdat); chk("tf_hi_again", 16'(rdat), 16'h0001);
        rd(3'd5, rdat); chk("tf_lo2", 16'(rdat), 16'h00F9);
        rd(3'd6, rdat); chk("tf_hi2", 16'(rdat), 16'h0000);
        wr(3'd2, 8'h00);
        rd(3'd5, rdat); chk("frz_a", 16'(rdat), 16'h00F6);
        repeat (3) @(negedge clk);
        rd(3'd5, rdat); chk("frz_b", 16'(rdat), 16'h00F6);

        // Writes to read-only addresses are ignored
        wr(3'd5, 8'hAA); rd(3'd5, rdat); chk("ro5", 16'(rdat), 16'h00F6);
        wr(3'd6, 8'hAA); rd(3'd6, rdat); chk("ro6", 16'(rdat), 16'h0000);
        wr(3'd7, 8'hAA); rd(3'd7, rdat); chk("ro7", 16'(rdat), 16'h0000);

        // Prescaler presence: PRESCALE=5, RELOAD=2, one-shot
        per = 3 * (PS_ON != 0 ? 6 : 1);
        wr(3'd4, 8'h05);
        rd(3'd4, rdat); chk("pre_rd", 16'(rdat), (PS_ON != 0) ? 16'h0005 : 16'h0000);
        wr(3'd0, 8'h02); wr(3'd1, 8'h00); wr(3'd2, 8'h05);
        repeat (per - 1) @(negedge clk);
        #1; chk("pre_before", 16'(irq), 16'h0);
        @(negedge clk);
        #1; chk("pre_set", 16'(irq), 16'h1);

        // Reset mid-run in periodic mode with COUNT=0x10 and irq pending
        wr(3'd0, 8'h10); wr(3'd1, 8'h00); wr(3'd2, 8'h07);
        chk("mr_irq_pre", 16'(irq), 16'h1);
        reset = 1'b1;
        #1;
        chk("mr_irq", 16'(irq), 16'h0);
        peek(3'd5, rdat); chk("mr_clo", 16'(rdat), 16'h0000);
        peek(3'd6, rdat); chk("mr_chi", 16'(rdat), 16'h0000);
        peek(3'd2, rdat); chk("mr_ctrl", 16'(rdat), 16'h0000);
        peek(3'd3, rdat); chk("mr_flag", 16'(rdat), 16'h0000);
        peek(3'd0, rdat); chk("mr_rlo", 16'(rdat), 16'h00FF);
        peek(3'd1, rdat); chk("mr_rhi", 16'(rdat), 16'h00FF);
        peek(3'd4, rdat); chk("mr_pre", 16'(rdat), 16'h0000);
        @(negedge clk);
        @(posedge clk);
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            chk("mr_quiet", 16'(irq), 16'h0);
        end
        peek(3'd5, rdat); chk("mr_cnt_idle", 16'(rdat), 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
